// File: rtl/portal_request_demux.sv
`default_nettype none
// ============================================================================
// Module      : portal_request_demux
// Description : Steers 32-bit request beats to per-channel assemblers and
//               enqueues completed messages into per-channel FWFT FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module portal_request_demux #(
    parameter int NCHAN      = 3,
    parameter int DEPTH      = 2,
    parameter int MAXWORDS   = 2,
    parameter logic [4*NCHAN-1:0] CHAN_WORDS = 12'h121,
    localparam int CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int MW        = 32 * MAXWORDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [CW-1:0]       req_chan,
    input  logic [31:0]         req_data,
    output logic                req_ready,
    input  logic [CW-1:0]       size_chan,
    output logic [15:0]         size_bits,
    input  logic [NCHAN-1:0]    deq_en,
    output logic [NCHAN*MW-1:0] deq_data,
    output logic [NCHAN-1:0]    not_empty,
    output logic [NCHAN-1:0]    not_full,
    output logic                intr_status,
    output logic [31:0]         intr_channel,
    input  logic                err_clr,
    output logic                err_oob
);

    localparam int CNTW = (MAXWORDS > 1) ? $clog2(MAXWORDS) : 1;
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW   = $clog2(DEPTH) + 1;
    localparam int NX   = 1 << CW;
    localparam logic [CW:0]   NCHAN_X = (CW+1)'(NCHAN);
    localparam logic [PW-1:0] PTR_MSB = PW'(1) << (PW - 1);

    logic             w_in_range;
    logic [NCHAN-1:0] w_last;
    logic [NX-1:0]    w_last_x;
    logic [NX-1:0]    w_nf_x;
    logic [NX-1:0]    w_deq_x;
    logic             err_q;
    logic             err_d;

    assign w_in_range = ({1'b0, req_chan} < NCHAN_X);

    // Channel-indexed vectors are padded to 2**CW so any req_chan value selects safely.
    assign w_last_x = NX'(w_last);
    assign w_nf_x   = NX'(not_full);
    assign w_deq_x  = NX'(deq_en);

    assign req_ready = ~w_in_range | ~w_last_x[req_chan] | w_nf_x[req_chan] | w_deq_x[req_chan];

    always_comb begin
        size_bits = '0;
        if ({1'b0, size_chan} < NCHAN_X) begin
            size_bits = 16'(32 * int'(CHAN_WORDS[4*int'(size_chan) +: 4]));
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        localparam int WORDS = int'(CHAN_WORDS[4*c +: 4]);

        logic [CNTW-1:0] cnt_q;
        logic [CNTW-1:0] cnt_d;
        logic [MW-1:0]   asm_q;
        logic [MW-1:0]   msg;
        logic [MW-1:0]   mem_q [DEPTH];
        logic [PW-1:0]   wr_q;
        logic [PW-1:0]   rd_q;
        logic [AW-1:0]   waddr;
        logic [AW-1:0]   raddr;
        logic            hit;
        logic            acc;
        logic            push;
        logic            pop;
        logic            empty;
        logic            full;

        assign hit   = req_valid & w_in_range & (req_chan == CW'(c));
        assign acc   = hit & req_ready;
        assign w_last[c] = (cnt_q == CNTW'(WORDS - 1));
        assign push  = acc & w_last[c];
        assign empty = (wr_q == rd_q);
        assign full  = ((wr_q ^ rd_q) == PTR_MSB);
        assign pop   = deq_en[c] & ~empty;
        assign waddr = (DEPTH == 1) ? '0 : wr_q[AW-1:0];
        assign raddr = (DEPTH == 1) ? '0 : rd_q[AW-1:0];

        // Words below the beat slot come from earlier beats, the slot takes the
        // incoming beat, and words above are zeroed so stale data never leaks.
        always_comb begin
            msg = '0;
            for (int k = 0; k < MAXWORDS; k++) begin
                if (k < int'(cnt_q)) begin
                    msg[32*k +: 32] = asm_q[32*k +: 32];
                end else if (k == int'(cnt_q)) begin
                    msg[32*k +: 32] = req_data;
                end
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (acc) begin
                cnt_d = w_last[c] ? '0 : cnt_q + CNTW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
            end else begin
                cnt_q <= cnt_d;
                if (push) wr_q <= wr_q + PW'(1);
                if (pop)  rd_q <= rd_q + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (acc)  asm_q        <= msg;
            if (push) mem_q[waddr] <= msg;
        end

        assign deq_data[c*MW +: MW] = mem_q[raddr];
        assign not_empty[c] = ~empty;
        assign not_full[c]  = ~full;
    end

    assign intr_status = |not_empty;

    always_comb begin
        intr_channel = 32'hFFFF_FFFF;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (not_empty[i]) intr_channel = 32'(i);
        end
    end

    // A new out-of-range beat outranks a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (req_valid && !w_in_range) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_oob = err_q;

endmodule
`default_nettype wire

// File: tb/tb_portal_request_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_portal_request_demux
// Description : Directed self-checking bench for portal_request_demux defaults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_portal_request_demux;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic [1:0]   req_chan;
    logic [31:0]  req_data;
    logic         req_ready;
    logic [1:0]   size_chan;
    logic [15:0]  size_bits;
    logic [2:0]   deq_en;
    logic [191:0] deq_data;
    logic [2:0]   not_empty;
    logic [2:0]   not_full;
    logic         intr_status;
    logic [31:0]  intr_channel;
    logic         err_clr;
    logic         err_oob;

    int n_tests;
    int n_fail;

    portal_request_demux dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_chan     (req_chan),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .size_chan    (size_chan),
        .size_bits    (size_bits),
        .deq_en       (deq_en),
        .deq_data     (deq_data),
        .not_empty    (not_empty),
        .not_full     (not_full),
        .intr_status  (intr_status),
        .intr_channel (intr_channel),
        .err_clr      (err_clr),
        .err_oob      (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] ch, input logic [31:0] d);
        req_valid = 1'b1;
        req_chan  = ch;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic deq(input logic [2:0] m);
        deq_en = m;
        tick();
        deq_en = 3'b000;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_chan = '0; req_data = '0;
        size_chan = '0; deq_en = '0; err_clr = 1'b0;
        #12;
        check("rst_not_empty", 64'(not_empty), 64'h0);
        check("rst_not_full", 64'(not_full), 64'h7);
        check("rst_intr_status", 64'(intr_status), 64'h0);
        check("rst_intr_channel", 64'(intr_channel), 64'hFFFF_FFFF);
        check("rst_err_oob", 64'(err_oob), 64'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            logic [15:0] exp_sz [4];
            exp_sz = '{16'd32, 16'd64, 16'd32, 16'd0};
            size_chan = 2'(i);
            #1;
            check($sformatf("size_bits_ch%0d", i), 64'(size_bits), 64'(exp_sz[i]));
        end

        // Dequeue on an empty FIFO must be ignored.
        deq(3'b111);
        check("deq_empty_nf", 64'(not_full), 64'h7);
        check("deq_empty_ne", 64'(not_empty), 64'h0);

        // Single-beat message on ch0.
        req_valid = 1'b1; req_chan = 2'd0; req_data = 32'hA5A5_A5A5;
        #1;
        check("ch0_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 1'b0;
        check("ch0_not_empty", 64'(not_empty), 64'h1);
        check("ch0_intr_channel", 64'(intr_channel), 64'h0);
        check("ch0_intr_status", 64'(intr_status), 64'h1);
        check("ch0_data", deq_data[63:0], 64'h0000_0000_A5A5_A5A5);
        deq(3'b001);
        check("ch0_drained", 64'(not_empty), 64'h0);

        // Interleaved two-beat ch1 message around a ch0 beat.
        beat(2'd1, 32'h1111_1111);
        check("ch1_partial", 64'(not_empty), 64'h0);
        beat(2'd0, 32'hBBBB_BBBB);
        check("ileave_ch0_only", 64'(not_empty), 64'h1);
        beat(2'd1, 32'h2222_2222);
        check("ileave_ne", 64'(not_empty), 64'h3);
        check("ileave_ch1_data", deq_data[127:64], 64'h2222_2222_1111_1111);
        check("ileave_ch0_data", deq_data[63:0], 64'h0000_0000_BBBB_BBBB);
        deq(3'b001);
        check("ileave_intr_ch1", 64'(intr_channel), 64'h1);
        deq(3'b010);
        check("ileave_drained", 64'(not_empty), 64'h0);

        // Fill ch2, block the third beat, then accept it with a same-cycle dequeue.
        beat(2'd2, 32'hC1C1_C1C1);
        beat(2'd2, 32'hC2C2_C2C2);
        req_valid = 1'b1; req_chan = 2'd2; req_data = 32'hC3C3_C3C3;
        #1;
        check("full_ready", 64'(req_ready), 64'h0);
        check("full_not_full", 64'(not_full), 64'h3);
        tick();
        check("full_hold_head", deq_data[191:128], 64'h0000_0000_C1C1_C1C1);
        deq_en = 3'b100;
        #1;
        check("full_deq_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 1'b0; deq_en = 3'b000;
        check("full_still_full", 64'(not_full), 64'h3);
        check("full_head_c2", deq_data[191:128], 64'h0000_0000_C2C2_C2C2);
        deq(3'b100);
        check("full_head_c3", deq_data[191:128], 64'h0000_0000_C3C3_C3C3);
        check("full_nf_after_pop", 64'(not_full), 64'h7);
        deq(3'b100);
        check("full_drained", 64'(not_empty), 64'h0);
        beat(2'd2, 32'hC4C4_C4C4);
        check("wrap_head_c4", deq_data[191:128], 64'h0000_0000_C4C4_C4C4);
        check("wrap_ne", 64'(not_empty), 64'h4);
        deq(3'b100);
        check("wrap_drained", 64'(not_empty), 64'h0);

        // Out-of-range channel and sticky error.
        req_valid = 1'b1; req_chan = 2'd3; req_data = 32'hDEAD_BEEF;
        #1;
        check("oob_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 1'b0;
        check("oob_err", 64'(err_oob), 64'h1);
        check("oob_no_fifo", 64'(not_empty), 64'h0);
        err_clr = 1'b1;
        beat(2'd3, 32'h0);
        check("oob_set_wins", 64'(err_oob), 64'h1);
        tick();
        err_clr = 1'b0;
        check("oob_cleared", 64'(err_oob), 64'h0);

        // Reset mid-assembly discards the partial ch1 message.
        beat(2'd1, 32'hDEAD_0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ne", 64'(not_empty), 64'h0);
        rst_n = 1'b1;
        tick();
        beat(2'd1, 32'h0000_0003);
        check("post_rst_partial", 64'(not_empty), 64'h0);
        beat(2'd1, 32'h0000_0004);
        check("post_rst_ne", 64'(not_empty), 64'h2);
        check("post_rst_data", deq_data[127:64], 64'h0000_0004_0000_0003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/portal_request_demux.md
PORTAL_REQUEST_DEMUX -- requirements
Module: portal_request_demux

Interface
REQ-001 SHALL have parameter NCHAN, default 3: number of request channels, range 1..16.
REQ-002 SHALL have parameter DEPTH, default 2: per-channel message FIFO depth, a power of 2, at least 1.
REQ-003 SHALL have parameter MAXWORDS, default 2: maximum message length in 32-bit words, range 1..8.
REQ-004 SHALL have parameter CHAN_WORDS, default 12'h121: packed 4 bits per channel (ch0 in LSBs) giving the word count per channel, each value 1..MAXWORDS.
REQ-005 SHALL use CW = max(1, clog2(NCHAN)) and MW = 32*MAXWORDS.
REQ-006 CLK  in  1  single clock; all state changes on the rising edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  a request beat is present.
REQ-009 req_chan  in  CW  destination channel of the beat.
REQ-010 req_data  in  32  beat payload.
REQ-011 req_ready  out  1  the beat is accepted this cycle when req_valid is also high.
REQ-012 size_chan  in  CW  channel whose size is queried.
REQ-013 size_bits  out  16  32*CHAN_WORDS[size_chan], combinational; 0 if size_chan >= NCHAN.
REQ-014 deq_en  in  NCHAN  per-channel dequeue strobes.
REQ-015 deq_data  out  NCHAN*MW  head message per channel (channel i at bits [i*MW +: MW]).
REQ-016 not_empty  out  NCHAN  per-channel FIFO non-empty.
REQ-017 not_full  out  NCHAN  per-channel FIFO not full.
REQ-018 intr_status  out  1  OR of not_empty.
REQ-019 intr_channel  out  32  index of the lowest non-empty channel; 32'hFFFFFFFF if none.
REQ-020 err_clr  in  1  clears err_oob.
REQ-021 err_oob  out  1  sticky flag: a beat arrived for a channel >= NCHAN.

Function
REQ-022 SHALL keep, per channel, an assembly register (MW bits) and a beat counter (0..CHAN_WORDS-1).
REQ-023 An accepted beat for channel c SHALL be written to word slot count[c] of the assembly register, with word 0 in the LSBs; unused upper words are zero.
REQ-024 On a non-final beat, the counter SHALL increment; on the final beat (count = CHAN_WORDS[c]-1), the counter SHALL return to 0 and the full message SHALL be enqueued into FIFO c in the same edge.
REQ-025 The final beat SHALL include itself in the enqueued message with no added latency; not_empty[c] SHALL rise the cycle after acceptance.
REQ-026 req_ready SHALL equal (req_chan >= NCHAN) OR (beat non-final) OR not_full[req_chan] OR deq_en[req_chan]; this gives a combinational path from deq_en to req_ready.
REQ-027 When a final beat and deq_en[c] occur together on a full FIFO, both SHALL occur; occupancy is unchanged.
REQ-028 Beats for different channels MAY interleave; each channel SHALL assemble independently.
REQ-029 A beat with req_chan >= NCHAN SHALL be dropped and SHALL set err_oob on the next edge; err_clr SHALL clear err_oob; if both occur in the same cycle, set SHALL win.
REQ-030 Each FIFO SHALL use read/write pointers of clog2(DEPTH)+1 bits that wrap modulo 2*DEPTH.
  - Full: the pointers differ only in the MSB.
  - Empty: the pointers are equal.
REQ-031 deq_en[c] while empty SHALL be ignored; deq_data for an empty FIFO is don't-care.
REQ-032 deq_data[c] SHALL present the head entry combinationally from FIFO storage (first-word fall-through).
REQ-033 intr_status and intr_channel SHALL be combinational from not_empty.

Reset
REQ-034 On RST_N low, all pointers, beat counters and err_oob SHALL clear asynchronously.
  - Outputs then read: not_empty = 0, not_full = all ones, intr_status = 0, intr_channel = 32'hFFFFFFFF, err_oob = 0.
REQ-035 A partially assembled message at reset SHALL be discarded; assembly data registers need no reset.

Verification
REQ-036 Defaults: send 1 beat 0xA5A5A5A5 to ch0 -> next cycle not_empty = 3'b001, intr_channel = 0, deq_data[31:0] = 0xA5A5A5A5, upper 32 bits = 0.
REQ-037 ch1 beats 0x11111111 then 0x22222222 with a ch0 beat between them -> the ch1 message is 64'h22222222_11111111; the ch0 message is intact.
REQ-038 Three single-beat messages to ch2 with no dequeue -> the third final beat has req_ready = 0 and not_full[2] = 0; assert deq_en[2] in that cycle -> the beat is accepted and occupancy stays 2; drain order is preserved across pointer wrap.
REQ-039 req_chan = 3 with req_valid -> req_ready = 1, no FIFO change, err_oob = 1 next cycle; err_clr together with another out-of-range beat -> err_oob stays 1.
REQ-040 Reset after the first ch1 beat -> not_empty = 0 and the counter is cleared; next ch1 beats 0x3 and 0x4 -> message 64'h00000004_00000003.
REQ-041 size_chan = 0, 1, 2, 3 -> size_bits = 32, 64, 32, 0.
